// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: opcodes, ALU ops,
// mux selects, FSM states and the per-state Moore control word.
package rv_ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_AND  = 3'b010,
    ALU_OR   = 3'b011,
    ALU_XOR  = 3'b100,
    ALU_SLT  = 3'b101,
    ALU_SLTU = 3'b110
  } alu_opc_t;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_src_t;

  typedef enum logic [1:0] {
    RES_ALUOUT  = 2'b00,
    RES_MEMDATA = 2'b01,
    RES_ALU     = 2'b10
  } result_src_t;

  typedef enum logic [1:0] {
    SRCA_PC    = 2'b00,
    SRCA_OLDPC = 2'b01,
    SRCA_RS1   = 2'b10,
    SRCA_ZERO  = 2'b11
  } src_a_t;

  typedef enum logic [1:0] {
    SRCB_RS2  = 2'b00,
    SRCB_IMM  = 2'b01,
    SRCB_FOUR = 2'b10
  } src_b_t;

  typedef enum logic [3:0] {
    S_RESET,
    S_FETCH,
    S_DECODE,
    S_MEM_ADR,
    S_MEM_READ,
    S_MEM_WB,
    S_MEM_WRITE,
    S_EXEC_R,
    S_EXEC_I,
    S_ALU_WB,
    S_BRANCH,
    S_JAL,
    S_JALR,
    S_JALR_WB,
    S_LUI
  } state_t;

  typedef struct packed {
    alu_opc_t    alu_opc;
    src_a_t      alu_src_a;
    src_b_t      alu_src_b;
    result_src_t result_src;
    logic        adr_src;
    logic        ir_write;
    logic        pc_write;
    logic        reg_write;
    logic        mem_write;
    logic        instr_retired;
  } ctrl_t;

  function automatic imm_src_t imm_src_of(logic [6:0] op);
    case (op)
      OP_STORE:  return IMM_S;
      OP_BRANCH: return IMM_B;
      OP_JAL:    return IMM_J;
      OP_LUI:    return IMM_U;
      default:   return IMM_I;
    endcase
  endfunction

  // beq/bge/bgeu take the branch when the ALU result is zero; bne/blt/bltu when it is not.
  function automatic logic branch_on_zero(logic [2:0] func3);
    return func3[2] ? func3[0] : ~func3[0];
  endfunction

  // Control word a state drives for its whole duration; opc only matters in EXEC_*/BRANCH.
  function automatic ctrl_t state_ctrl(state_t s, alu_opc_t opc);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.ir_write   = 1'b1;
        c.alu_src_b  = SRCB_FOUR;
        c.result_src = RES_ALU;
        c.pc_write   = 1'b1;
      end
      S_DECODE: begin
        c.alu_src_a = SRCA_OLDPC;
        c.alu_src_b = SRCB_IMM;
      end
      S_MEM_ADR: begin
        c.alu_src_a = SRCA_RS1;
        c.alu_src_b = SRCB_IMM;
      end
      S_MEM_READ: c.adr_src = 1'b1;
      S_MEM_WB: begin
        c.result_src    = RES_MEMDATA;
        c.reg_write     = 1'b1;
        c.instr_retired = 1'b1;
      end
      S_MEM_WRITE: begin
        c.adr_src       = 1'b1;
        c.mem_write     = 1'b1;
        c.instr_retired = 1'b1;
      end
      S_EXEC_R: begin
        c.alu_src_a = SRCA_RS1;
        c.alu_opc   = opc;
      end
      S_EXEC_I: begin
        c.alu_src_a = SRCA_RS1;
        c.alu_src_b = SRCB_IMM;
        c.alu_opc   = opc;
      end
      S_ALU_WB: begin
        c.reg_write     = 1'b1;
        c.instr_retired = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a     = SRCA_RS1;
        c.alu_opc       = opc;
        c.instr_retired = 1'b1;
      end
      S_JAL: begin
        c.alu_src_a = SRCA_OLDPC;
        c.alu_src_b = SRCB_FOUR;
        c.pc_write  = 1'b1;
      end
      S_JALR: begin
        c.alu_src_a  = SRCA_RS1;
        c.alu_src_b  = SRCB_IMM;
        c.result_src = RES_ALU;
        c.pc_write   = 1'b1;
      end
      S_JALR_WB: begin
        c.alu_src_a     = SRCA_OLDPC;
        c.alu_src_b     = SRCB_FOUR;
        c.result_src    = RES_ALU;
        c.reg_write     = 1'b1;
        c.instr_retired = 1'b1;
      end
      S_LUI: begin
        c.alu_src_a = SRCA_ZERO;
        c.alu_src_b = SRCB_IMM;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multi_cycle_controller_if.sv
// Controller <-> datapath bundle: instruction fields and ALU flag in, control word out.
interface multi_cycle_controller_if;

  logic [6:0] op;
  logic [2:0] func3;
  logic       func7b5;
  logic       zero;

  logic [2:0] alu_opc;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] imm_src;
  logic [1:0] result_src;
  logic       adr_src;
  logic       ir_write;
  logic       pc_write;
  logic       reg_write;
  logic       mem_write;
  logic       instr_retired;

  modport master (
    input  op, func3, func7b5, zero,
    output alu_opc, alu_src_a, alu_src_b, imm_src, result_src,
           adr_src, ir_write, pc_write, reg_write, mem_write, instr_retired
  );

  modport slave (
    output op, func3, func7b5, zero,
    input  alu_opc, alu_src_a, alu_src_b, imm_src, result_src,
           adr_src, ir_write, pc_write, reg_write, mem_write, instr_retired
  );

endinterface

// File: rtl/alu_decoder.sv
// Combinational ALU operation select for R-type, I-type ALU and branch instructions.
module alu_decoder
  import rv_ctrl_pkg::*;
(
  input  logic [6:0] op,
  input  logic [2:0] func3,
  input  logic       func7b5,
  output alu_opc_t   alu_opc
);

  always_comb begin
    // NOTE: default assigned first so every path drives alu_opc and no latch is inferred.
    alu_opc = ALU_ADD;
    case (op)
      OP_R, OP_I: begin
        case (func3)
          3'b000:  alu_opc = (op == OP_R && func7b5) ? ALU_SUB : ALU_ADD;
          3'b111:  alu_opc = ALU_AND;
          3'b110:  alu_opc = ALU_OR;
          3'b100:  alu_opc = ALU_XOR;
          3'b010:  alu_opc = ALU_SLT;
          3'b011:  alu_opc = ALU_SLTU;
          default: alu_opc = ALU_ADD;
        endcase
      end
      OP_BRANCH: begin
        case (func3[2:1])
          2'b00:   alu_opc = ALU_SUB;
          2'b10:   alu_opc = ALU_SLT;
          2'b11:   alu_opc = ALU_SLTU;
          default: alu_opc = ALU_ADD;
        endcase
      end
      default: alu_opc = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multi_cycle_controller.sv
// Main control FSM of the multi-cycle RV32I core. Control word is registered from the
// next state; only imm_src (follows op) and the branch pc_write (follows zero) are combinational.
module multi_cycle_controller
  import rv_ctrl_pkg::*;
(
  input logic                      clk,
  input logic                      rst_n,
  multi_cycle_controller_if.master bus
);

  state_t   state;
  state_t   state_nxt;
  ctrl_t    ctrl_q;
  alu_opc_t dec_opc;

  alu_decoder u_alu_decoder (
    .op      (bus.op),
    .func3   (bus.func3),
    .func7b5 (bus.func7b5),
    .alu_opc (dec_opc)
  );

  always_comb begin
    state_nxt = S_FETCH;
    case (state)
      S_RESET:  state_nxt = S_FETCH;
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: begin
        case (bus.op)
          OP_LOAD, OP_STORE: state_nxt = S_MEM_ADR;
          OP_R:              state_nxt = S_EXEC_R;
          OP_I:              state_nxt = S_EXEC_I;
          OP_BRANCH:         state_nxt = S_BRANCH;
          OP_JAL:            state_nxt = S_JAL;
          OP_JALR:           state_nxt = S_JALR;
          OP_LUI:            state_nxt = S_LUI;
          default:           state_nxt = S_FETCH;  // illegal opcode: drop it silently
        endcase
      end
      S_MEM_ADR:  state_nxt = (bus.op == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ: state_nxt = S_MEM_WB;
      S_EXEC_R, S_EXEC_I, S_JAL, S_LUI: state_nxt = S_ALU_WB;
      S_JALR:     state_nxt = S_JALR_WB;
      default:    state_nxt = S_FETCH;
    endcase
  end

  // op is only valid from DECODE on, so the opc captured here is consumed no earlier
  // than the DECODE -> EXEC/BRANCH edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_RESET;
      ctrl_q <= '0;
    end else begin
      // NOTE: non-blocking so state and ctrl_q both update from pre-edge values.
      state  <= state_nxt;
      ctrl_q <= state_ctrl(state_nxt, dec_opc);
    end
  end

  assign bus.alu_opc       = ctrl_q.alu_opc;
  assign bus.alu_src_a     = ctrl_q.alu_src_a;
  assign bus.alu_src_b     = ctrl_q.alu_src_b;
  assign bus.result_src    = ctrl_q.result_src;
  assign bus.adr_src       = ctrl_q.adr_src;
  assign bus.ir_write      = ctrl_q.ir_write;
  assign bus.reg_write     = ctrl_q.reg_write;
  assign bus.mem_write     = ctrl_q.mem_write;
  assign bus.instr_retired = ctrl_q.instr_retired;

  assign bus.imm_src  = (state == S_RESET || state == S_FETCH) ? IMM_I : imm_src_of(bus.op);
  assign bus.pc_write = ctrl_q.pc_write |
                        ((state == S_BRANCH) && (bus.zero == branch_on_zero(bus.func3)));

endmodule
